snn_fc_layer: RTL and testbench

- Parametrised fully-connected spiking-network layer engine, successor to the fixed-size snn_core datapath.
- Streams inputs and signed weights from synchronous-read memories, then multiply-accumulates, scales, saturates and optionally applies ReLU per neuron.
- Writes each neuron result to an output memory and tracks a running argmax, so one instance serves as the hidden layer and another as the digit classifier.

---
 rtl/snn_pkg.sv | 47 ++++
 rtl/snn_sat_relu.sv | 27 ++
 rtl/snn_fc_layer.sv | 141 ++++++++++++++
 tb/tb_snn_fc_layer.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the fully-connected spiking layer engine.
// Holds the state encoding, the saturation helper and the default layer shapes.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } layer_state_t;

    // Hidden layer: 784 binary pixels into 32 neurons.
    localparam int HID_N_IN   = 784;
    localparam int HID_N_OUT  = 32;
    localparam int HID_IN_W   = 1;
    localparam int HID_ACC_W  = 20;
    localparam int HID_SHIFT  = 0;
    localparam int HID_RELU   = 1;

    // Classifier layer: 32 hidden activations into 10 digits.
    localparam int CLS_N_IN   = 32;
    localparam int CLS_N_OUT  = 10;
    localparam int CLS_IN_W   = 8;
    localparam int CLS_ACC_W  = 20;
    localparam int CLS_SHIFT  = 0;
    localparam int CLS_RELU   = 0;

    localparam int DEF_W_W    = 8;
    localparam int DEF_OUT_W  = 8;

    // Clamp a signed value into the range of a signed number of the given width.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/snn_sat_relu.sv
// Output stage for one neuron: arithmetic shift, signed saturation and optional ReLU.
// Purely combinational so the result is ready in the same cycle the accumulator settles.
module snn_sat_relu
    import snn_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int SHIFT = 0,
    parameter int OUT_W = 8,
    parameter int RELU  = 1
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_data
);

    logic signed [ACC_W-1:0] w_shifted;

    assign w_shifted = i_acc >>> SHIFT;

    // After saturation the value fits OUT_W, so its top bit is the true sign.
    always_comb begin
        o_data = OUT_W'(sat_signed(64'(w_shifted), OUT_W));
        if (RELU != 0 && o_data[OUT_W-1]) begin
            o_data = '0;
        end
    end

endmodule

// File: rtl/snn_fc_layer.sv
// Fully-connected spiking layer: streams inputs and weights, accumulates per neuron,
// writes each saturated result and keeps a running argmax across the layer.
module snn_fc_layer
    import snn_pkg::*;
#(
    parameter int N_IN  = 784,
    parameter int N_OUT = 32,
    parameter int IN_W  = 1,
    parameter int W_W   = 8,
    parameter int ACC_W = 20,
    parameter int SHIFT = 0,
    parameter int OUT_W = 8,
    parameter int RELU  = 1,
    localparam int IA_W = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int OA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [IA_W-1:0]         in_addr,
    input  logic [IN_W-1:0]         in_q,
    output logic [WA_W-1:0]         w_addr,
    input  logic signed [W_W-1:0]   w_q,
    output logic [OA_W-1:0]         out_addr,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_we,
    output logic                    busy,
    output logic                    done,
    output logic [OA_W-1:0]         max_idx,
    output logic signed [OUT_W-1:0] max_val,
    output layer_state_t            dbg_state
);

    layer_state_t            r_state;
    logic [IA_W-1:0]         r_i;
    logic [OA_W-1:0]         r_n;
    logic [WA_W-1:0]         r_w_addr;
    logic signed [ACC_W-1:0] r_acc;
    logic [OA_W-1:0]         r_max_idx;
    logic signed [OUT_W-1:0] r_max_val;

    logic signed [ACC_W-1:0] w_term;
    logic signed [OUT_W-1:0] w_sat;
    logic                    w_acc_en;

    generate
        if (IN_W == 1) begin : g_binary
            assign w_term = in_q[0] ? ACC_W'(w_q) : '0;
        end else begin : g_multibit
            logic signed [IN_W+W_W:0] w_prod;
            assign w_prod = $signed({1'b0, in_q}) * w_q;
            assign w_term = ACC_W'(w_prod);
        end
    endgenerate

    // Memory data trails the address by one cycle, so the pair for address r_i-1 is on the bus.
    assign w_acc_en = ((r_state == ST_MAC) && (r_i != '0)) || (r_state == ST_DRAIN);

    snn_sat_relu #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W),
        .RELU  (RELU)
    ) u_sat_relu (
        .i_acc  (r_acc),
        .o_data (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_i       <= '0;
            r_n       <= '0;
            r_w_addr  <= '0;
            r_acc     <= '0;
            r_max_idx <= '0;
            r_max_val <= '0;
        end else begin
            if (w_acc_en) begin
                r_acc <= r_acc + w_term;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_MAC;
                        r_i      <= '0;
                        r_n      <= '0;
                        r_w_addr <= '0;
                        r_acc    <= '0;
                    end
                end
                ST_MAC: begin
                    if (r_i == IA_W'(N_IN - 1)) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_i      <= r_i + 1'b1;
                        r_w_addr <= r_w_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    // Strict compare keeps the lowest index on ties.
                    if (r_n == '0 || w_sat > r_max_val) begin
                        r_max_idx <= r_n;
                        r_max_val <= w_sat;
                    end
                    if (r_n == OA_W'(N_OUT - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state  <= ST_MAC;
                        r_n      <= r_n + 1'b1;
                        r_i      <= '0;
                        r_w_addr <= r_w_addr + 1'b1;
                        r_acc    <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_addr   = r_i;
    assign w_addr    = r_w_addr;
    assign out_addr  = r_n;
    assign out_we    = (r_state == ST_WRITE);
    assign out_data  = out_we ? w_sat : '0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign max_idx   = r_max_idx;
    assign max_val   = r_max_val;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_snn_fc_layer.sv
// Bench for snn_fc_layer: three small layer configurations driven from shared memories,
// each pass compared against an arithmetic reference of the layer maths and timing.
module tb_snn_fc_layer;
    import snn_pkg::*;

    // Handshake: start is a level sampled only while idle; each result is taken when out_we is high.

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic [1:0] in_addr_a, in_addr_b;
    logic [0:0] in_addr_c;
    logic [0:0] in_q_a = '0, in_q_b = '0;
    logic [7:0] in_q_c = '0;
    logic [3:0] w_addr_a, w_addr_b;
    logic [2:0] w_addr_c;
    logic [7:0] w_q_a = '0, w_q_b = '0, w_q_c = '0;
    logic [1:0] out_addr_a, out_addr_b, out_addr_c;
    logic [7:0] out_data_a, out_data_b, out_data_c;
    logic       out_we_a, out_we_b, out_we_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [1:0] max_idx_a, max_idx_b, max_idx_c;
    logic [7:0] max_val_a, max_val_b, max_val_c;
    layer_state_t st_a, st_b, st_c;

    int in_mem[0:3];
    int w_mem[0:15];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0 = 0;
    bit mon_en = 1'b0;
    logic [1:0] sel = 2'd0;

    logic       m_we, m_done;
    logic [1:0] m_addr, m_max_idx;
    logic [7:0] m_data, m_max_val;

    logic [7:0] obs_data_q[$];
    logic [1:0] obs_addr_q[$];
    int         obs_cyc_q[$];
    int         done_cyc_q[$];

    logic [7:0] exp_q[$];
    logic [1:0] exp_addr_q[$];
    int         exp_cyc_q[$];
    int         exp_done_q[$];
    logic [1:0] exp_max_idx;
    logic [7:0] exp_max_val;

    snn_fc_layer #(.N_IN(4), .N_OUT(3), .IN_W(1), .W_W(8), .ACC_W(12), .SHIFT(0),
                   .OUT_W(8), .RELU(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_addr(in_addr_a), .in_q(in_q_a),
        .w_addr(w_addr_a), .w_q(w_q_a), .out_addr(out_addr_a), .out_data(out_data_a),
        .out_we(out_we_a), .busy(busy_a), .done(done_a), .max_idx(max_idx_a),
        .max_val(max_val_a), .dbg_state(st_a));

    snn_fc_layer #(.N_IN(4), .N_OUT(3), .IN_W(1), .W_W(8), .ACC_W(12), .SHIFT(0),
                   .OUT_W(8), .RELU(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_addr(in_addr_b), .in_q(in_q_b),
        .w_addr(w_addr_b), .w_q(w_q_b), .out_addr(out_addr_b), .out_data(out_data_b),
        .out_we(out_we_b), .busy(busy_b), .done(done_b), .max_idx(max_idx_b),
        .max_val(max_val_b), .dbg_state(st_b));

    snn_fc_layer #(.N_IN(2), .N_OUT(3), .IN_W(8), .W_W(8), .ACC_W(20), .SHIFT(1),
                   .OUT_W(8), .RELU(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .in_addr(in_addr_c), .in_q(in_q_c),
        .w_addr(w_addr_c), .w_q(w_q_c), .out_addr(out_addr_c), .out_data(out_data_c),
        .out_we(out_we_c), .busy(busy_c), .done(done_c), .max_idx(max_idx_c),
        .max_val(max_val_c), .dbg_state(st_c));

    // ---------------- clock / memories / monitor ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        in_q_a <= in_mem[in_addr_a][0];
        in_q_b <= in_mem[in_addr_b][0];
        in_q_c <= in_mem[in_addr_c][7:0];
        w_q_a  <= w_mem[w_addr_a][7:0];
        w_q_b  <= w_mem[w_addr_b][7:0];
        w_q_c  <= w_mem[w_addr_c][7:0];
    end

    always_comb begin
        case (sel)
            2'd0: begin
                m_we = out_we_a; m_done = done_a; m_addr = out_addr_a; m_data = out_data_a;
                m_max_idx = max_idx_a; m_max_val = max_val_a;
            end
            2'd1: begin
                m_we = out_we_b; m_done = done_b; m_addr = out_addr_b; m_data = out_data_b;
                m_max_idx = max_idx_b; m_max_val = max_val_b;
            end
            default: begin
                m_we = out_we_c; m_done = done_c; m_addr = out_addr_c; m_data = out_data_c;
                m_max_idx = max_idx_c; m_max_val = max_val_c;
            end
        endcase
    end

    // Cycle numbers are relative to the edge that sampled start (cycle 0).
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_we) begin
                obs_data_q.push_back(m_data);
                obs_addr_q.push_back(m_addr);
                obs_cyc_q.push_back(cyc - c0 + 1);
            end
            if (m_done) begin
                done_cyc_q.push_back(cyc - c0 + 1);
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic clear_expect();
        exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete(); exp_done_q.delete();
    endtask

    task automatic build_expect(input int n_in, input bit binary, input int acc_w,
                                input int shift, input bit relu, input int offset);
        longint sum, m, best;
        int x, bidx;
        best = 0; bidx = 0;
        for (int n = 0; n < 3; n++) begin
            sum = 0;
            for (int i = 0; i < n_in; i++) begin
                x = binary ? (in_mem[i] & 1) : (in_mem[i] & 255);
                sum += longint'(x) * longint'(w_mem[n * n_in + i]);
            end
            m = longint'(1) << acc_w;
            sum = ((sum % m) + m) % m;
            if (sum >= m / 2) sum -= m;
            sum = sum >>> shift;
            if (sum > 127) sum = 127;
            if (sum < -128) sum = -128;
            if (relu && sum < 0) sum = 0;
            exp_q.push_back(8'(sum));
            exp_addr_q.push_back(2'(n));
            exp_cyc_q.push_back(offset + (n + 1) * (n_in + 2));
            if (n == 0 || sum > best) begin
                best = sum;
                bidx = n;
            end
        end
        exp_done_q.push_back(offset + 3 * (n_in + 2) + 1);
        exp_max_idx = 2'(bidx);
        exp_max_val = 8'(best);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_pass(input int s, input bit hold);
        sel = 2'(s);
        mon_en = 1'b0;
        obs_data_q.delete(); obs_addr_q.delete(); obs_cyc_q.delete(); done_cyc_q.delete();
        @(negedge clk);
        case (s)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk);
        #1;
        c0 = cyc;
        mon_en = 1'b1;
        @(negedge clk);
        if (!hold) begin
            start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        end
    endtask

    task automatic wait_dones(input int n, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (done_cyc_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s timeout: got %0d done pulses, want %0d", nm, done_cyc_q.size(), n);
        end
    endtask

    task automatic set_w4(input int n, input int w0, input int w1, input int w2, input int w3);
        w_mem[n * 4 + 0] = w0; w_mem[n * 4 + 1] = w1;
        w_mem[n * 4 + 2] = w2; w_mem[n * 4 + 3] = w3;
    endtask

    task automatic load_basic();
        in_mem[0] = 1; in_mem[1] = 0; in_mem[2] = 1; in_mem[3] = 1;
        set_w4(0, 10, 20, 30, -5);
        set_w4(1, -100, 0, 0, 0);
        set_w4(2, 50, 0, 0, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, out_we_a, out_data_a, out_addr_a} !== 12'd0 || st_a !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_a_outputs: got busy=%0b done=%0b we=%0b data=%0d addr=%0d, want all 0",
                     busy_a, done_a, out_we_a, out_data_a, out_addr_a);
        end
        checks++;
        if ({in_addr_a, w_addr_a, max_idx_a, max_val_a} !== 16'd0) begin
            failures++;
            $display("FAIL reset_a_addr: got in=%0d w=%0d max_idx=%0d max_val=%0d, want 0",
                     in_addr_a, w_addr_a, max_idx_a, max_val_a);
        end
        checks++;
        if ({busy_b, done_b, out_we_b, busy_c, done_c, out_we_c, max_val_c} !== 14'd0) begin
            failures++;
            $display("FAIL reset_bc: got busy_b=%0b busy_c=%0b we_c=%0b max_val_c=%0d, want 0",
                     busy_b, busy_c, out_we_c, max_val_c);
        end
    endtask

    task automatic test_basic();
        load_basic();
        clear_expect();
        build_expect(4, 1'b1, 12, 0, 1'b1, 0);
        start_pass(0, 1'b0);
        wait_dones(1, "basic");
        checks++;
        if (obs_data_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL basic write_count: got %0d want %0d", obs_data_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_data_q.size(); k++) begin
            checks++;
            if (obs_data_q[k] !== exp_q[k] || obs_addr_q[k] !== exp_addr_q[k] || obs_cyc_q[k] != exp_cyc_q[k]) begin
                failures++;
                $display("FAIL basic write%0d: got data=%0d addr=%0d cyc=%0d want data=%0d addr=%0d cyc=%0d",
                         k, $signed(obs_data_q[k]), obs_addr_q[k], obs_cyc_q[k],
                         $signed(exp_q[k]), exp_addr_q[k], exp_cyc_q[k]);
            end
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != exp_done_q[0]) begin
            failures++;
            $display("FAIL basic done: got %0d pulses first=%0d want 1 at %0d", done_cyc_q.size(),
                     (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, exp_done_q[0]);
        end
        checks++;
        if (m_max_idx !== exp_max_idx || m_max_val !== exp_max_val) begin
            failures++;
            $display("FAIL basic argmax: got idx=%0d val=%0d want idx=%0d val=%0d",
                     m_max_idx, $signed(m_max_val), exp_max_idx, $signed(exp_max_val));
        end
    endtask

    task automatic test_saturation();
        load_basic();
        set_w4(0, 127, 127, 127, 127);
        start_pass(0, 1'b0);
        wait_dones(1, "sat_pos");
        checks++;
        if (obs_data_q.size() < 1 || obs_data_q[0] !== 8'd127) begin
            failures++;
            $display("FAIL sat_pos: got %0d writes first=%0d want 127", obs_data_q.size(),
                     (obs_data_q.size() > 0) ? $signed(obs_data_q[0]) : 0);
        end
        set_w4(0, -128, -128, -128, -128);
        start_pass(1, 1'b0);
        wait_dones(1, "sat_neg");
        checks++;
        if (obs_data_q.size() < 1 || obs_data_q[0] !== 8'h80) begin
            failures++;
            $display("FAIL sat_neg: got %0d writes first=%0d want -128", obs_data_q.size(),
                     (obs_data_q.size() > 0) ? $signed(obs_data_q[0]) : 0);
        end
    endtask

    task automatic test_tie();
        load_basic();
        set_w4(0, 40, 0, 0, 0);
        set_w4(1, 12, 0, 0, 0);
        set_w4(2, 0, 0, 40, 0);
        start_pass(0, 1'b0);
        wait_dones(1, "tie");
        checks++;
        if (m_max_idx !== 2'd0 || m_max_val !== 8'd40) begin
            failures++;
            $display("FAIL tie argmax: got idx=%0d val=%0d want idx=0 val=40", m_max_idx, $signed(m_max_val));
        end
    endtask

    task automatic test_start_ignored();
        load_basic();
        clear_expect();
        build_expect(4, 1'b1, 12, 0, 1'b1, 0);
        start_pass(0, 1'b0);
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_dones(1, "start_ignored");
        repeat (10) @(negedge clk);
        checks++;
        if (obs_data_q.size() != 3 || done_cyc_q.size() != 1) begin
            failures++;
            $display("FAIL start_ignored counts: got writes=%0d dones=%0d want writes=3 dones=1",
                     obs_data_q.size(), done_cyc_q.size());
        end
        for (int k = 0; k < 3 && k < obs_data_q.size(); k++) begin
            checks++;
            if (obs_data_q[k] !== exp_q[k] || obs_cyc_q[k] != exp_cyc_q[k]) begin
                failures++;
                $display("FAIL start_ignored write%0d: got data=%0d cyc=%0d want data=%0d cyc=%0d",
                         k, $signed(obs_data_q[k]), obs_cyc_q[k], $signed(exp_q[k]), exp_cyc_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        load_basic();
        start_pass(0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, out_we_a, out_data_a, out_addr_a, in_addr_a, w_addr_a,
             max_idx_a, max_val_a} !== 28'd0) begin
            failures++;
            $display("FAIL reset_mid outputs: got busy=%0b we=%0b in=%0d w=%0d max_idx=%0d max_val=%0d want 0",
                     busy_a, out_we_a, in_addr_a, w_addr_a, max_idx_a, max_val_a);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (obs_data_q.size() != 1 || done_cyc_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid abort: got writes=%0d dones=%0d want writes=1 dones=0",
                     obs_data_q.size(), done_cyc_q.size());
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_expect();
        build_expect(4, 1'b1, 12, 0, 1'b1, 0);
        start_pass(0, 1'b0);
        wait_dones(1, "reset_mid_restart");
        checks++;
        if (obs_data_q.size() != 3) begin
            failures++;
            $display("FAIL reset_mid restart_count: got %0d want 3", obs_data_q.size());
        end
        for (int k = 0; k < 3 && k < obs_data_q.size(); k++) begin
            checks++;
            if (obs_data_q[k] !== exp_q[k] || obs_cyc_q[k] != exp_cyc_q[k]) begin
                failures++;
                $display("FAIL reset_mid write%0d: got data=%0d cyc=%0d want data=%0d cyc=%0d",
                         k, $signed(obs_data_q[k]), obs_cyc_q[k], $signed(exp_q[k]), exp_cyc_q[k]);
            end
        end
        checks++;
        if (m_max_idx !== exp_max_idx || m_max_val !== exp_max_val) begin
            failures++;
            $display("FAIL reset_mid argmax: got idx=%0d val=%0d want idx=%0d val=%0d",
                     m_max_idx, $signed(m_max_val), exp_max_idx, $signed(exp_max_val));
        end
    endtask

    task automatic test_multibit();
        in_mem[0] = 3; in_mem[1] = 200;
        w_mem[0] = 4; w_mem[1] = -1;
        for (int j = 2; j < 6; j++) w_mem[j] = int'($urandom_range(0, 255)) - 128;
        clear_expect();
        build_expect(2, 1'b0, 20, 1, 1'b0, 0);
        start_pass(2, 1'b0);
        wait_dones(1, "multibit");
        checks++;
        if (obs_data_q.size() < 1 || obs_data_q[0] !== 8'(-94)) begin
            failures++;
            $display("FAIL multibit n0: got %0d writes first=%0d want -94", obs_data_q.size(),
                     (obs_data_q.size() > 0) ? $signed(obs_data_q[0]) : 0);
        end
        for (int k = 0; k < 3 && k < obs_data_q.size(); k++) begin
            checks++;
            if (obs_data_q[k] !== exp_q[k] || obs_cyc_q[k] != exp_cyc_q[k]) begin
                failures++;
                $display("FAIL multibit write%0d: got data=%0d cyc=%0d want data=%0d cyc=%0d",
                         k, $signed(obs_data_q[k]), obs_cyc_q[k], $signed(exp_q[k]), exp_cyc_q[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            bit multi;
            multi = (r % 2) == 1;
            for (int i = 0; i < 4; i++) in_mem[i] = multi ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 1));
            for (int j = 0; j < 16; j++) w_mem[j] = int'($urandom_range(0, 255)) - 128;
            clear_expect();
            if (multi) build_expect(2, 1'b0, 20, 1, 1'b0, 0);
            else       build_expect(4, 1'b1, 12, 0, 1'b1, 0);
            start_pass(multi ? 2 : 0, 1'b0);
            wait_dones(1, "random");
            checks++;
            if (obs_data_q.size() != 3) begin
                failures++;
                $display("FAIL random%0d write_count: got %0d want 3", r, obs_data_q.size());
            end
            for (int k = 0; k < 3 && k < obs_data_q.size(); k++) begin
                checks++;
                if (obs_data_q[k] !== exp_q[k] || obs_addr_q[k] !== exp_addr_q[k]) begin
                    failures++;
                    $display("FAIL random%0d write%0d: got data=%0d addr=%0d want data=%0d addr=%0d",
                             r, k, $signed(obs_data_q[k]), obs_addr_q[k], $signed(exp_q[k]), exp_addr_q[k]);
                end
            end
            checks++;
            if (m_max_idx !== exp_max_idx || m_max_val !== exp_max_val) begin
                failures++;
                $display("FAIL random%0d argmax: got idx=%0d val=%0d want idx=%0d val=%0d",
                         r, m_max_idx, $signed(m_max_val), exp_max_idx, $signed(exp_max_val));
            end
        end
    endtask

    task automatic test_back_to_back();
        load_basic();
        clear_expect();
        build_expect(4, 1'b1, 12, 0, 1'b1, 0);
        build_expect(4, 1'b1, 12, 0, 1'b1, 3 * (4 + 2) + 2);
        start_pass(0, 1'b1);
        for (int k = 0; k < 100 && (cyc - c0) < 21; k++) @(negedge clk);
        start_a = 1'b0;
        wait_dones(2, "back_to_back");
        checks++;
        if (obs_data_q.size() != 6 || done_cyc_q.size() != 2) begin
            failures++;
            $display("FAIL back_to_back counts: got writes=%0d dones=%0d want writes=6 dones=2",
                     obs_data_q.size(), done_cyc_q.size());
        end
        for (int k = 0; k < 6 && k < obs_data_q.size(); k++) begin
            checks++;
            if (obs_data_q[k] !== exp_q[k] || obs_cyc_q[k] != exp_cyc_q[k]) begin
                failures++;
                $display("FAIL back_to_back write%0d: got data=%0d cyc=%0d want data=%0d cyc=%0d",
                         k, $signed(obs_data_q[k]), obs_cyc_q[k], $signed(exp_q[k]), exp_cyc_q[k]);
            end
        end
        for (int k = 0; k < 2 && k < done_cyc_q.size(); k++) begin
            checks++;
            if (done_cyc_q[k] != exp_done_q[k]) begin
                failures++;
                $display("FAIL back_to_back done%0d: got cyc=%0d want cyc=%0d", k, done_cyc_q[k], exp_done_q[k]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 4; i++) in_mem[i] = 0;
        for (int j = 0; j < 16; j++) w_mem[j] = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_tie();
        test_start_ignored();
        test_reset_mid_pass();
        test_multibit();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
